// File: rtl/summation_grid_pkg.sv
// Shared definitions for the summation_grid slide-and-merge engine.
// Optional score accumulation in the top is controlled by SUMMATION_SCORE_EN.
package summation_pkg;

  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PROC = 2'd2,
    DONE = 2'd3
  } state_t;

  // True only for exactly one of the four direction bits.
  function automatic logic dir_valid(input logic [3:0] d);
    logic v;
    case (d)
      DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT: v = 1'b1;
      default:                               v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/summation_grid_if.sv
// Move request / result bundle between the direction decoder and summation_grid.
interface summation_grid_if #(
  parameter int N       = 4,
  parameter int TILE_W  = 12,
  parameter int SCORE_W = 16
) ();
  logic                    start;
  logic [3:0]              direction;
  logic [N*N*TILE_W-1:0]   matrix;
  logic [N*N*TILE_W-1:0]   summed_matrix;
  logic                    busy;
  logic                    ready;
  logic                    moved;
  logic                    overflow;
  logic [SCORE_W-1:0]      score_delta;

  modport master (
    output start, direction, matrix,
    input  summed_matrix, busy, ready, moved, overflow, score_delta
  );

  modport slave (
    input  start, direction, matrix,
    output summed_matrix, busy, ready, moved, overflow, score_delta
  );
endinterface

// File: rtl/summation_grid_line.sv
// Combinational compact-and-merge of one N-tile line; element 0 is the destination side.
module summation_line #(
  parameter int N      = 4,
  parameter int TILE_W = 12
) (
  input  logic [N*TILE_W-1:0] line_in,
  output logic [N*TILE_W-1:0] line_out,
  output logic [TILE_W+3:0]   sum,
  output logic                saturate
);

  localparam logic [TILE_W:0] MAX_V = {1'b0, {TILE_W{1'b1}}};

  // Extra trailing zero slot lets the pair scan look one past the end safely.
  logic [TILE_W-1:0] comp_s [N+1];

  // Compact non-zero tiles toward element 0, preserving order.
  always_comb begin
    int cnt;
    cnt = 0;
    for (int i = 0; i <= N; i++) begin
      comp_s[i] = {TILE_W{1'b0}};
    end
    for (int i = 0; i < N; i++) begin
      if (line_in[i*TILE_W +: TILE_W] != {TILE_W{1'b0}}) begin
        comp_s[cnt] = line_in[i*TILE_W +: TILE_W];
        cnt = cnt + 1;
      end else begin
        cnt = cnt;
      end
    end
  end

  // Merge equal adjacent pairs once each, saturating the tile value.
  always_comb begin
    int               j;
    logic             skip;
    logic [TILE_W:0]  dbl;
    j        = 0;
    skip     = 1'b0;
    dbl      = {(TILE_W+1){1'b0}};
    line_out = {(N*TILE_W){1'b0}};
    sum      = {(TILE_W+4){1'b0}};
    saturate = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (comp_s[i] == {TILE_W{1'b0}}) begin
        skip = 1'b0;
      end else if (comp_s[i] == comp_s[i+1]) begin
        dbl  = {comp_s[i], 1'b0};
        sum  = sum + (TILE_W+4)'(dbl);
        skip = 1'b1;
        if (dbl > MAX_V) begin
          line_out[j*TILE_W +: TILE_W] = {TILE_W{1'b1}};
          saturate = 1'b1;
        end else begin
          line_out[j*TILE_W +: TILE_W] = dbl[TILE_W-1:0];
        end
        j = j + 1;
      end else begin
        line_out[j*TILE_W +: TILE_W] = comp_s[i];
        j = j + 1;
      end
    end
  end

endmodule

// File: rtl/summation_grid.sv
// Sequential N x N slide-and-merge move, one line per clock.
// Define SUMMATION_SCORE_EN to build the per-move score accumulator.
module summation_grid
  import summation_pkg::*;
#(
  parameter int N       = 4,
  parameter int TILE_W  = 12,
  parameter int SCORE_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  summation_grid_if.slave bus
);

  localparam int GW  = N * N * TILE_W;
  localparam int K_W = (N > 1) ? $clog2(N) : 1;

  state_t             state_r;
  logic [3:0]         dir_r;
  logic [GW-1:0]      grid_r;
  logic [K_W-1:0]     k_r;
  logic [GW-1:0]      summed_r;
  logic               busy_r;
  logic               ready_r;
  logic               moved_r;
  logic               ovf_r;

  logic [N*TILE_W-1:0] line_in_s;
  logic [N*TILE_W-1:0] line_out_s;
  logic [GW-1:0]       next_grid_s;
  logic [TILE_W+3:0]   line_sum_s;
  logic                line_sat_s;

  summation_line #(.N(N), .TILE_W(TILE_W)) u_line (
    .line_in  (line_in_s),
    .line_out (line_out_s),
    .sum      (line_sum_s),
    .saturate (line_sat_s)
  );

  // Map line k of the captured grid to/from destination-first order.
  always_comb begin
    int r;
    int c;
    int kk;
    kk          = int'(k_r);
    line_in_s   = {(N*TILE_W){1'b0}};
    next_grid_s = grid_r;
    for (int i = 0; i < N; i++) begin
      case (dir_r)
        DIR_LEFT:  begin r = kk;        c = i;         end
        DIR_RIGHT: begin r = kk;        c = N - 1 - i; end
        DIR_UP:    begin r = i;         c = kk;        end
        DIR_DOWN:  begin r = N - 1 - i; c = kk;        end
        default:   begin r = kk;        c = i;         end
      endcase
      line_in_s[i*TILE_W +: TILE_W]             = grid_r[((r*N)+c)*TILE_W +: TILE_W];
      next_grid_s[((r*N)+c)*TILE_W +: TILE_W]   = line_out_s[i*TILE_W +: TILE_W];
    end
  end

  // Move sequencer with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      dir_r    <= 4'b0000;
      grid_r   <= {GW{1'b0}};
      k_r      <= {K_W{1'b0}};
      summed_r <= {GW{1'b0}};
      busy_r   <= 1'b0;
      ready_r  <= 1'b0;
      moved_r  <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          ready_r <= 1'b0;
          if (bus.start) begin
            grid_r  <= bus.matrix;
            dir_r   <= bus.direction;
            busy_r  <= 1'b1;
            state_r <= LOAD;
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD: begin
          moved_r <= 1'b0;
          ovf_r   <= 1'b0;
          if (dir_valid(dir_r)) begin
            k_r     <= {K_W{1'b0}};
            state_r <= PROC;
          end else begin
            summed_r <= grid_r;
            busy_r   <= 1'b0;
            ready_r  <= 1'b1;
            state_r  <= DONE;
          end
        end
        PROC: begin
          grid_r  <= next_grid_s;
          moved_r <= moved_r | (line_out_s != line_in_s);
          ovf_r   <= ovf_r | line_sat_s;
          if (k_r == K_W'(N - 1)) begin
            summed_r <= next_grid_s;
            busy_r   <= 1'b0;
            ready_r  <= 1'b1;
            state_r  <= DONE;
          end else begin
            k_r <= k_r + {{(K_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          busy_r  <= 1'b0;
          ready_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.summed_matrix = summed_r;
  assign bus.busy          = busy_r;
  assign bus.ready         = ready_r;
  assign bus.moved         = moved_r;
  assign bus.overflow      = ovf_r;

`ifdef SUMMATION_SCORE_EN
  localparam int ACC_W = ((SCORE_W > TILE_W + 4) ? SCORE_W : TILE_W + 4) + 1;

  logic [SCORE_W-1:0] score_r;
  logic [ACC_W-1:0]   score_sum_s;

  assign score_sum_s = ACC_W'(score_r) + ACC_W'(line_sum_s);

  // Saturating accumulation of unsaturated merge sums across the move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_r <= {SCORE_W{1'b0}};
    end else if (state_r == LOAD) begin
      score_r <= {SCORE_W{1'b0}};
    end else if (state_r == PROC) begin
      if (score_sum_s > ACC_W'({SCORE_W{1'b1}})) begin
        score_r <= {SCORE_W{1'b1}};
      end else begin
        score_r <= score_sum_s[SCORE_W-1:0];
      end
    end else begin
      score_r <= score_r;
    end
  end

  assign bus.score_delta = score_r;
`else
  logic unused_s;
  assign unused_s        = ^line_sum_s;
  assign bus.score_delta = {SCORE_W{1'b0}};
`endif

endmodule

// File: doc/summation_grid.md
Name: summation_grid

Overview:
- Parametrised, sequential successor to the 2048 summation stage: performs one full slide-and-merge move on an N x N tile grid.
- Processes one line (row or column) per clock.
- Adds start/done handshake, moved flag, saturation flag and per-move score.
- Sits between the direction decoder and the random-tile spawner in game_logic.

Parameters:
- N, 4, grid dimension (lines and tiles per line); legal range 2..8.
- TILE_W, 12, bits per tile; tiles hold literal values (0, 2, 4, ...), 0 = empty.
- SCORE_W, 16, width of score_delta.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a move; sampled only when busy=0.
- direction  in  4  one-hot: [3]=up, [2]=down, [1]=left, [0]=right.
- matrix  in  N*N*TILE_W  flattened grid; tile (r,c) at bits ((r*N)+c)*TILE_W +: TILE_W; row 0 = top, col 0 = left.
- summed_matrix  out  N*N*TILE_W  result grid, same packing.
- busy  out  1  high while a move is in progress.
- ready  out  1  one-cycle pulse; result is valid.
- moved  out  1  result differs from captured grid; valid with ready, held until next start.
- overflow  out  1  at least one merge saturated; valid with ready, held until next start.
- score_delta  out  SCORE_W  sum of merged tile values for this move.

Behaviour:
- Reset, async on rst_n low: state IDLE; summed_matrix=0, busy=0, ready=0, moved=0, overflow=0, score_delta=0, internal grid and counters cleared. Reset mid-move aborts with no ready pulse.
- States: IDLE -> LOAD -> PROC -> DONE -> IDLE.
- IDLE/DONE, busy=0: start=1 captures matrix and direction and enters LOAD. A start in DONE is accepted; ready still pulses that cycle.
- LOAD, busy=1:
  - Valid one-hot direction: clear moved/overflow/score, line counter=0, go to PROC.
  - Any other direction (0 or more than one bit set): copy grid unchanged to summed_matrix, moved=0, go to DONE.
- PROC, busy=1: each cycle processes line k (k = 0..N-1), then writes it back.
  - Line extraction by direction:
    - left: row k, c ascending. right: row k, c descending.
    - up: column k, r ascending. down: column k, r descending.
  - Line op, element 0 = destination side:
    - Compact non-zeros toward element 0, preserving order.
    - Scan pairs from element 0: equal adjacent non-zero pair becomes one tile of 2v, next tile skipped.
    - Each tile merges at most once per move.
    - Pad with zeros.
  - Merge sum: if 2v > 2^TILE_W-1, result = 2^TILE_W-1 and overflow is set.
  - score_delta += unsaturated 2v, saturating at 2^SCORE_W-1.
  - moved is ORed with (line_out != line_in).
  - After k = N-1, go to DONE.
- DONE: ready=1 for exactly one cycle; summed_matrix updated; busy=0. Next state IDLE unless start is accepted.
- Latency, valid direction: start sampled at edge t -> ready high in the cycle after edge t+N+1. For N=4 that is 6 edges after the start edge. Invalid direction: ready after 2 edges.
- summed_matrix, moved, overflow, score_delta hold their values until the next accepted start enters LOAD.
- start while busy=1 is ignored, not queued.
- matrix/direction changes after capture have no effect on the move in progress.

Optional Feature:
- Macro SUMMATION_SCORE_EN.
- Defined: score accumulation as described above.
- Undefined: no score adder or register; score_delta tied to 0. Port list is identical in both builds.

Decomposition:
- Package summation_pkg holds:
  - direction constants DIR_UP=4'b1000, DIR_DOWN=4'b0100, DIR_LEFT=4'b0010, DIR_RIGHT=4'b0001;
  - state enum (IDLE, LOAD, PROC, DONE);
  - a function that checks for a valid one-hot direction.
- Sub-module summation_line: combinational N-tile compact/merge. Parameters N and TILE_W; outputs line_out, merged value sum, saturate flag. Instantiated once and reused each PROC cycle.

Test Plan:
- Left; row 0 = [2,2,2,2], other rows zero -> row 0 = [4,4,0,0]; score_delta=8; moved=1; ready after 6 edges.
- Left; row 0 = [2,0,2,4] -> [4,4,0,0], no double merge; score_delta=4. Right; row 1 = [2,2,2,0] -> [0,0,2,4].
- Up; column 0 top-to-bottom = [2,2,8,8] -> [4,16,0,0]; score_delta=20; other columns unchanged.
- Left; rows [2,4,8,16] with no possible merge -> grid unchanged, moved=0, score_delta=0; invalid direction 4'b1010 -> ready after 2 edges, unchanged grid, moved=0.
- TILE_W=12; left on row [2048,2048,0,0] -> [4095,0,0,0], overflow=1. Second start asserted while busy -> ignored, exactly one ready pulse.
- rst_n low during PROC -> all outputs 0 immediately, no ready. A later start runs a clean move. Without SUMMATION_SCORE_EN, score_delta stays 0 throughout.
